// File: rtl/reg_bank_if.sv
// reg_bank_if: write/read bus of the register bank; the master drives addresses and data.
interface reg_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              wr_ack;
    modport master (output clr, we, waddr, wdata, raddr_a, raddr_b, input rdata_a, rdata_b, wr_ack);
    modport slave  (input clr, we, waddr, wdata, raddr_a, raddr_b, output rdata_a, rdata_b, wr_ack);
endinterface

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file, one write port, two registered read ports.
module reg_bank #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic        clk,
    input logic        reset,
    reg_bank_if.slave  bus
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_wr_ack;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // clr suppresses the write, which also disables forwarding that cycle
    assign w_wr_ok = !bus.clr && bus.we && (int'(bus.waddr) < DEPTH)
                     && !(ZERO_REG != 0 && bus.waddr == '0);

    function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
        if (int'(a) >= DEPTH || (ZERO_REG != 0 && a == '0)) return '0;
        if (BYPASS != 0 && w_wr_ok && a == bus.waddr) return bus.wdata;
        return r_mem[a];
    endfunction

    always_comb begin
        w_rd_a = rd(bus.raddr_a);
        w_rd_b = rd(bus.raddr_b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_wr_ack  <= 1'b0;
        end else begin
            r_rdata_a <= w_rd_a;
            r_rdata_b <= w_rd_b;
            r_wr_ack  <= w_wr_ok;
            if (bus.clr) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            end else if (w_wr_ok) begin
                r_mem[bus.waddr] <= bus.wdata;
            end
        end
    end

    assign bus.rdata_a = r_rdata_a;
    assign bus.rdata_b = r_rdata_b;
    assign bus.wr_ack  = r_wr_ack;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed vectors against a default bank (u0) and a DEPTH=6, no-zero, no-bypass bank (u1).
module tb_reg_bank;
    logic       clk = 1'b0;
    logic       reset, clr, we;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp0 [8];
    logic [7:0] exp1 [6];

    reg_bank_if #(.WIDTH(8), .ADDR_W(3)) if0 ();
    reg_bank_if #(.WIDTH(8), .ADDR_W(3)) if1 ();

    assign {if0.clr, if0.we, if0.waddr, if0.wdata, if0.raddr_a, if0.raddr_b} = {clr, we, waddr, wdata, raddr_a, raddr_b};
    assign {if1.clr, if1.we, if1.waddr, if1.wdata, if1.raddr_a, if1.raddr_b} = {clr, we, waddr, wdata, raddr_a, raddr_b};

    reg_bank u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    reg_bank #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; clr = 0; we = 1; waddr = 3; wdata = 8'hAA; raddr_a = 3; raddr_b = 3;
        tick(); tick();
        chk("rst u0 a", if0.rdata_a, 8'h00); chk("rst u0 b", if0.rdata_b, 8'h00); chk("rst u0 ack", {7'b0, if0.wr_ack}, 8'h00);
        chk("rst u1 a", if1.rdata_a, 8'h00); chk("rst u1 b", if1.rdata_b, 8'h00); chk("rst u1 ack", {7'b0, if1.wr_ack}, 8'h00);
        reset = 0; we = 0;
        tick();
        chk("post rst u0 a3", if0.rdata_a, 8'h00); chk("post rst u1 a3", if1.rdata_a, 8'h00);
        // write then read
        we = 1; waddr = 5; wdata = 8'h5C;
        tick();
        chk("wr5 u0 ack", {7'b0, if0.wr_ack}, 8'h01); chk("wr5 u1 ack", {7'b0, if1.wr_ack}, 8'h01);
        we = 0; raddr_a = 5; raddr_b = 4;
        tick();
        chk("rd5 u0 a", if0.rdata_a, 8'h5C); chk("rd4 u0 b", if0.rdata_b, 8'h00);
        chk("rd5 u1 a", if1.rdata_a, 8'h5C); chk("rd4 u1 b", if1.rdata_b, 8'h00);
        chk("idle u0 ack", {7'b0, if0.wr_ack}, 8'h00);
        // bypass
        we = 1; waddr = 2; wdata = 8'h11;
        tick();
        wdata = 8'h22; raddr_a = 2;
        tick();
        chk("byp u0 a", if0.rdata_a, 8'h22); chk("nobyp u1 a", if1.rdata_a, 8'h11);
        we = 0;
        tick();
        chk("after byp u0 a", if0.rdata_a, 8'h22); chk("after byp u1 a", if1.rdata_a, 8'h22);
        // register 0
        we = 1; waddr = 0; wdata = 8'hFF; raddr_a = 0; raddr_b = 0;
        tick();
        chk("wr0 u0 ack", {7'b0, if0.wr_ack}, 8'h00); chk("wr0 u1 ack", {7'b0, if1.wr_ack}, 8'h01);
        chk("wr0 u1 a old", if1.rdata_a, 8'h00);
        we = 0;
        tick();
        chk("rd0 u0 a", if0.rdata_a, 8'h00); chk("rd0 u0 b", if0.rdata_b, 8'h00);
        chk("rd0 u1 a", if1.rdata_a, 8'hFF); chk("rd0 u1 b", if1.rdata_b, 8'hFF);
        // out of range for u1, in range for u0
        we = 1; waddr = 7; wdata = 8'h77;
        tick();
        chk("wr7 u0 ack", {7'b0, if0.wr_ack}, 8'h01); chk("wr7 u1 ack", {7'b0, if1.wr_ack}, 8'h00);
        we = 0; raddr_a = 7; raddr_b = 6;
        tick();
        chk("rd7 u0 a", if0.rdata_a, 8'h77); chk("rd7 u1 a", if1.rdata_a, 8'h00); chk("rd6 u1 b", if1.rdata_b, 8'h00);
        exp0 = '{8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h5C, 8'h00, 8'h77};
        exp1 = '{8'hFF, 8'h00, 8'h22, 8'h00, 8'h00, 8'h5C};
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(i);
            tick();
            chk($sformatf("keep u0 %0d", i), if0.rdata_a, exp0[i]);
            if (i < 6) chk($sformatf("keep u1 %0d", i), if1.rdata_b, exp1[i]);
        end
        // fill 1..7, then clear
        for (int i = 1; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 8'(8'h30 + i);
            tick();
            chk($sformatf("fill u0 ack %0d", i), {7'b0, if0.wr_ack}, 8'h01);
            chk($sformatf("fill u1 ack %0d", i), {7'b0, if1.wr_ack}, (i < 6) ? 8'h01 : 8'h00);
        end
        clr = 1; we = 1; waddr = 4; wdata = 8'hEE; raddr_a = 3; raddr_b = 7;
        tick();
        chk("clr u0 a old", if0.rdata_a, 8'h33); chk("clr u0 b old", if0.rdata_b, 8'h37);
        chk("clr u1 a old", if1.rdata_a, 8'h33); chk("clr u1 b", if1.rdata_b, 8'h00);
        chk("clr u0 ack", {7'b0, if0.wr_ack}, 8'h00); chk("clr u1 ack", {7'b0, if1.wr_ack}, 8'h00);
        clr = 0; we = 0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            tick();
            chk($sformatf("cleared u0 %0d", i), if0.rdata_a, 8'h00);
            chk($sformatf("cleared u1 %0d", i), if1.rdata_a, 8'h00);
        end
        // reset beats clr and write
        we = 1; waddr = 1; wdata = 8'h99;
        tick();
        reset = 1; clr = 1; waddr = 1; wdata = 8'h55; raddr_a = 1; raddr_b = 1;
        tick();
        chk("rst+clr u0 a", if0.rdata_a, 8'h00); chk("rst+clr u0 b", if0.rdata_b, 8'h00); chk("rst+clr u0 ack", {7'b0, if0.wr_ack}, 8'h00);
        chk("rst+clr u1 a", if1.rdata_a, 8'h00); chk("rst+clr u1 ack", {7'b0, if1.wr_ack}, 8'h00);
        reset = 0; clr = 0; we = 0;
        tick();
        chk("after rst u0 a1", if0.rdata_a, 8'h00); chk("after rst u1 b1", if1.rdata_b, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised multi-register storage block: the generalised successor of the single-bit D flip-flop stage.
- Holds DEPTH registers of WIDTH bits each.
- One synchronous write port and two registered read ports, with optional write-to-read bypass and an optional hardwired-zero register 0.
- Sits between the decode and execute stages of the microprocessor datapath as the general-purpose register file.

Parameters:
- WIDTH, 8, bits per register and per data port.
- DEPTH, 8, number of registers; must satisfy 2 <= DEPTH <= 2^ADDR_W.
- ADDR_W, 3, address width of all address ports.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read output; 0 = the read returns the pre-write value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- clr  input  1  synchronous clear of all registers; read outputs are unaffected.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  ADDR_W  read address, port A.
- rdata_a  output  WIDTH  registered read data, port A.
- raddr_b  input  ADDR_W  read address, port B.
- rdata_b  output  WIDTH  registered read data, port B.
- wr_ack  output  1  pulses high for one cycle after each accepted write.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - reset is synchronous and active-high.
  - On a rising edge with reset=1: all DEPTH registers, rdata_a, rdata_b and wr_ack become 0.
  - reset overrides clr, we and all reads in the same cycle.
- clr (reset=0, clr=1) at the edge:
  - All registers become 0.
  - Any write that cycle is dropped and wr_ack <= 0.
  - Reads that cycle still execute and return the pre-clear contents; BYPASS does not apply.
- Write accepted (reset=0, clr=0, we=1) when:
  - waddr < DEPTH, and
  - not (ZERO_REG=1 and waddr=0).
- On an accepted write: mem[waddr] <= wdata and wr_ack <= 1 in that edge. Otherwise wr_ack <= 0.
- Rejected writes (out-of-range address or protected register 0): storage unchanged, wr_ack=0.
- Reads: each port is evaluated independently every non-reset edge, giving 1-cycle latency from raddr to rdata.
  - raddr >= DEPTH -> rdata <= 0.
  - ZERO_REG=1 and raddr=0 -> rdata <= 0.
  - BYPASS=1, an accepted write this cycle and waddr=raddr -> rdata <= wdata.
  - Otherwise -> rdata <= mem[raddr], the value before this edge's write.
- Both ports may read the same address; both then return identical data.
- No read side effects. Outputs hold their last value only until the next edge; a new value is loaded every edge.
- Register contents persist indefinitely without writes.
- Width rules: no arithmetic; data is stored and returned bit-exact; no truncation or extension.
- Reset mid-operation: a write presented in the same cycle as reset is lost; the first post-reset edge behaves as from power-up.
- X on raddr with reset=0 is a bench error; RTL is not required to mask it.

Test Plan:
- Reset: hold reset=1 for 2 edges with we=1, waddr=3, wdata=8'hAA -> rdata_a=rdata_b=0, wr_ack=0; reading addr 3 after release returns 8'h00.
- Write then read:
  - Write 8'h5C to addr 5 -> wr_ack=1 next cycle.
  - Next cycle raddr_a=5 -> rdata_a=8'h5C one edge later.
  - raddr_b=4 -> rdata_b=8'h00.
- Bypass:
  - Addr 2 holds 8'h11. Same cycle: we=1, waddr=2, wdata=8'h22, raddr_a=2 -> rdata_a=8'h22 with BYPASS=1, 8'h11 with BYPASS=0.
  - Following read of addr 2 returns 8'h22 in both cases.
- Zero register:
  - ZERO_REG=1, write 8'hFF to addr 0 -> wr_ack=0; reading addr 0 on both ports returns 8'h00.
  - Repeat with ZERO_REG=0 -> wr_ack=1, reads return 8'hFF.
- Out of range (DEPTH=6, ADDR_W=3): write 8'h77 to addr 7 -> wr_ack=0; reading addr 7 returns 8'h00; addrs 0-5 unchanged.
- Clear and precedence:
  - Fill addrs 1-7 with distinct values.
  - Assert clr with raddr_a=3 -> rdata_a returns the old addr-3 value; next read of any address returns 0.
  - Assert reset and clr together with a write -> write dropped, all outputs 0.
